sauria_result_checker: RTL and testbench



---
 rtl/sauria_result_checker.sv | 270 +++++++++++++++++++++++++++
 tb/tb_sauria_result_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sauria_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : sauria_result_checker
//  Purpose  : Walks a byte-address range, reads the acquired and the golden
//             memory one word at a time and compares them, either exactly or
//             per FP16 lane within TOL_ULP ULPs. Keeps mismatch and check
//             counts and records the address of the first failing word.
//  Options  : SAURIA_CHECKER_TOL_EN - when defined, the per-lane tolerance
//             compare is built and i_mode selects it; when undefined, every
//             word is compared exactly and i_mode is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module sauria_result_checker #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 32,
  parameter int LANE_W  = 16,
  parameter int TOL_ULP = 8
) (
  input  logic              i_system_clk,
  input  logic              i_system_rstn,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_end_addr,
  output logic              o_acq_req_valid,
  input  logic              i_acq_req_ready,
  output logic [ADDR_W-1:0] o_acq_req_addr,
  input  logic              i_acq_rsp_valid,
  input  logic [DATA_W-1:0] i_acq_rsp_data,
  output logic              o_gld_req_valid,
  input  logic              i_gld_req_ready,
  output logic [ADDR_W-1:0] o_gld_req_addr,
  input  logic              i_gld_rsp_valid,
  input  logic [DATA_W-1:0] i_gld_rsp_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_err_cnt,
  output logic [31:0]       o_chk_cnt,
  output logic              o_first_err_valid,
  output logic [ADDR_W-1:0] o_first_err_addr
);

  localparam int C_BYTES = DATA_W / 8;
  localparam int C_OFF   = $clog2(C_BYTES);
  localparam int C_NL    = DATA_W / LANE_W;
  localparam int C_ICW   = $clog2(C_NL + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_CMP   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [ADDR_W-C_OFF-1:0]   end_word_q, end_word_d;
  logic                      mode_q, mode_d;
  logic                      acq_acc_q, acq_acc_d;
  logic                      gld_acc_q, gld_acc_d;
  logic                      acq_got_q, acq_got_d;
  logic                      gld_got_q, gld_got_d;
  logic [DATA_W-1:0]         acq_data_q, acq_data_d;
  logic [DATA_W-1:0]         gld_data_q, gld_data_d;
  logic [31:0]               err_cnt_q, err_cnt_d;
  logic [31:0]               chk_cnt_q, chk_cnt_d;
  logic                      first_err_valid_q, first_err_valid_d;
  logic [ADDR_W-1:0]         first_err_addr_q, first_err_addr_d;

  logic                      w_acq_fire;
  logic                      w_gld_fire;
  logic                      w_word_ne;
  logic [C_ICW-1:0]          w_inc;
  logic [32:0]               w_err_sum;
  logic                      w_last;

  assign w_word_ne = (acq_data_q != gld_data_q);

`ifdef SAURIA_CHECKER_TOL_EN
  logic [C_NL-1:0]           w_lane_fail;
  logic [C_ICW-1:0]          w_tol_cnt;

  // Each lane: map sign-magnitude to a two's-complement ordinal so that +0 and
  // -0 coincide, then flag the lane if the ordinal distance exceeds TOL_ULP.
  for (genvar l = 0; l < C_NL; l++) begin : g_lane
    logic [LANE_W-1:0] w_a;
    logic [LANE_W-1:0] w_g;
    logic [LANE_W:0]   w_a_ord;
    logic [LANE_W:0]   w_g_ord;
    logic [LANE_W:0]   w_diff;
    logic [LANE_W:0]   w_abs;

    assign w_a     = acq_data_q[l*LANE_W +: LANE_W];
    assign w_g     = gld_data_q[l*LANE_W +: LANE_W];
    assign w_a_ord = w_a[LANE_W-1] ? ((LANE_W+1)'(0) - {2'b00, w_a[LANE_W-2:0]})
                                   : {2'b00, w_a[LANE_W-2:0]};
    assign w_g_ord = w_g[LANE_W-1] ? ((LANE_W+1)'(0) - {2'b00, w_g[LANE_W-2:0]})
                                   : {2'b00, w_g[LANE_W-2:0]};
    assign w_diff  = w_a_ord - w_g_ord;
    assign w_abs   = w_diff[LANE_W] ? ((LANE_W+1)'(0) - w_diff) : w_diff;
    assign w_lane_fail[l] = (w_abs > (LANE_W+1)'(TOL_ULP));
  end

  // Population count of failing lanes in the held word pair.
  always_comb begin
    w_tol_cnt = '0;
    for (int l = 0; l < C_NL; l++) begin
      w_tol_cnt = w_tol_cnt + C_ICW'(w_lane_fail[l]);
    end
  end

  assign w_inc = mode_q ? w_tol_cnt : C_ICW'(w_word_ne);
`else
  logic unused_mode;

  assign unused_mode = mode_q;
  assign w_inc       = C_ICW'(w_word_ne);
`endif

  assign w_err_sum = {1'b0, err_cnt_q} + 33'(w_inc);
  assign w_last    = (end_word_q == addr_q[ADDR_W-1:C_OFF]);

  // Request valids drop as soon as their own handshake has completed.
  assign o_acq_req_valid = (state_q == S_REQ) && !acq_acc_q;
  assign o_gld_req_valid = (state_q == S_REQ) && !gld_acc_q;
  assign w_acq_fire      = o_acq_req_valid && i_acq_req_ready;
  assign w_gld_fire      = o_gld_req_valid && i_gld_req_ready;

  // Next-state, handshake tracking, response capture and counter updates.
  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    end_word_d        = end_word_q;
    mode_d            = mode_q;
    acq_acc_d         = acq_acc_q;
    gld_acc_d         = gld_acc_q;
    acq_got_d         = acq_got_q;
    gld_got_d         = gld_got_q;
    acq_data_d        = acq_data_q;
    gld_data_d        = gld_data_q;
    err_cnt_d         = err_cnt_q;
    chk_cnt_d         = chk_cnt_q;
    first_err_valid_d = first_err_valid_q;
    first_err_addr_d  = first_err_addr_q;

    if (w_acq_fire) acq_acc_d = 1'b1;
    if (w_gld_fire) gld_acc_d = 1'b1;

    // Responses are only meaningful for a request already accepted; they are
    // expected no earlier than the cycle after acceptance.
    if (state_q == S_REQ || state_q == S_WAIT || state_q == S_DRAIN) begin
      if (acq_acc_q && !acq_got_q && i_acq_rsp_valid) begin
        acq_got_d  = 1'b1;
        acq_data_d = i_acq_rsp_data;
      end
      if (gld_acc_q && !gld_got_q && i_gld_rsp_valid) begin
        gld_got_d  = 1'b1;
        gld_data_d = i_gld_rsp_data;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d            = i_start_addr;
          end_word_d        = i_end_addr[ADDR_W-1:C_OFF];
          mode_d            = i_mode;
          acq_acc_d         = 1'b0;
          gld_acc_d         = 1'b0;
          acq_got_d         = 1'b0;
          gld_got_d         = 1'b0;
          err_cnt_d         = '0;
          chk_cnt_d         = '0;
          first_err_valid_d = 1'b0;
          first_err_addr_d  = '0;
          state_d           = (i_end_addr < i_start_addr) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (i_abort)                     state_d = S_DRAIN;
        else if (acq_acc_d && gld_acc_d) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_abort)                     state_d = S_DRAIN;
        else if (acq_got_d && gld_got_d) state_d = S_CMP;
      end
      S_CMP: begin
        err_cnt_d = w_err_sum[32] ? 32'hFFFF_FFFF : w_err_sum[31:0];
        if (chk_cnt_q != 32'hFFFF_FFFF) chk_cnt_d = chk_cnt_q + 32'd1;
        if (w_inc != '0 && !first_err_valid_q) begin
          first_err_valid_d = 1'b1;
          first_err_addr_d  = addr_q;
        end
        acq_acc_d = 1'b0;
        gld_acc_d = 1'b0;
        acq_got_d = 1'b0;
        gld_got_d = 1'b0;
        addr_d    = addr_q + ADDR_W'(C_BYTES);
        if (i_abort)     state_d = S_DRAIN;
        else if (w_last) state_d = S_DONE;
        else             state_d = S_REQ;
      end
      S_DRAIN: begin
        if (!(acq_acc_d && !acq_got_d) && !(gld_acc_d && !gld_got_d)) begin
          acq_acc_d = 1'b0;
          gld_acc_d = 1'b0;
          acq_got_d = 1'b0;
          gld_got_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge i_system_clk or negedge i_system_rstn) begin
    if (!i_system_rstn) begin
      state_q           <= S_IDLE;
      addr_q            <= '0;
      end_word_q        <= '0;
      mode_q            <= 1'b0;
      acq_acc_q         <= 1'b0;
      gld_acc_q         <= 1'b0;
      acq_got_q         <= 1'b0;
      gld_got_q         <= 1'b0;
      acq_data_q        <= '0;
      gld_data_q        <= '0;
      err_cnt_q         <= '0;
      chk_cnt_q         <= '0;
      first_err_valid_q <= 1'b0;
      first_err_addr_q  <= '0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      end_word_q        <= end_word_d;
      mode_q            <= mode_d;
      acq_acc_q         <= acq_acc_d;
      gld_acc_q         <= gld_acc_d;
      acq_got_q         <= acq_got_d;
      gld_got_q         <= gld_got_d;
      acq_data_q        <= acq_data_d;
      gld_data_q        <= gld_data_d;
      err_cnt_q         <= err_cnt_d;
      chk_cnt_q         <= chk_cnt_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_addr_q  <= first_err_addr_d;
    end
  end

  assign o_acq_req_addr    = addr_q;
  assign o_gld_req_addr    = addr_q;
  assign o_busy            = (state_q == S_REQ) || (state_q == S_WAIT) ||
                             (state_q == S_CMP) || (state_q == S_DRAIN);
  assign o_done            = (state_q == S_DONE);
  assign o_err_cnt         = err_cnt_q;
  assign o_chk_cnt         = chk_cnt_q;
  assign o_first_err_valid = first_err_valid_q;
  assign o_first_err_addr  = first_err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_sauria_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sauria_result_checker
//  Purpose  : Directed self-checking bench for sauria_result_checker with a
//             two-port memory responder of programmable latency and stall.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sauria_result_checker;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              mode = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic              acq_req_valid;
  logic              acq_req_ready = 1'b1;
  logic [ADDR_W-1:0] acq_req_addr;
  logic              acq_rsp_valid = 1'b0;
  logic [DATA_W-1:0] acq_rsp_data = '0;
  logic              gld_req_valid;
  logic              gld_req_ready = 1'b1;
  logic [ADDR_W-1:0] gld_req_addr;
  logic              gld_rsp_valid = 1'b0;
  logic [DATA_W-1:0] gld_rsp_data = '0;
  logic              busy;
  logic              done;
  logic [31:0]       err_cnt;
  logic [31:0]       chk_cnt;
  logic              first_err_valid;
  logic [ADDR_W-1:0] first_err_addr;

  logic [DATA_W-1:0] acq_mem [16];
  logic [DATA_W-1:0] gld_mem [16];
  logic [DATA_W-1:0] acq_pend = '0;
  logic [DATA_W-1:0] gld_pend = '0;
  int acq_lat = 1, gld_lat = 1, gld_stall = 0;
  int acq_dn = 0, gld_dn = 0;
  int acq_reqs = 0, gld_reqs = 0, done_pulses = 0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  sauria_result_checker #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .LANE_W (16), .TOL_ULP (8)
  ) dut (
    .i_system_clk      (clk),
    .i_system_rstn     (rstn),
    .i_start           (start),
    .i_abort           (abort),
    .i_mode            (mode),
    .i_start_addr      (start_addr),
    .i_end_addr        (end_addr),
    .o_acq_req_valid   (acq_req_valid),
    .i_acq_req_ready   (acq_req_ready),
    .o_acq_req_addr    (acq_req_addr),
    .i_acq_rsp_valid   (acq_rsp_valid),
    .i_acq_rsp_data    (acq_rsp_data),
    .o_gld_req_valid   (gld_req_valid),
    .i_gld_req_ready   (gld_req_ready),
    .o_gld_req_addr    (gld_req_addr),
    .i_gld_rsp_valid   (gld_rsp_valid),
    .i_gld_rsp_data    (gld_rsp_data),
    .o_busy            (busy),
    .o_done            (done),
    .o_err_cnt         (err_cnt),
    .o_chk_cnt         (chk_cnt),
    .o_first_err_valid (first_err_valid),
    .o_first_err_addr  (first_err_addr)
  );

  // Memory responder: decides handshakes on the falling edge so that what it
  // sees is exactly what the DUT samples on the next rising edge.
  always @(negedge clk) begin
    acq_rsp_valid = 1'b0;
    gld_rsp_valid = 1'b0;
    if (acq_dn > 0) begin
      acq_dn = acq_dn - 1;
      if (acq_dn == 0) begin acq_rsp_valid = 1'b1; acq_rsp_data = acq_pend; end
    end
    if (gld_dn > 0) begin
      gld_dn = gld_dn - 1;
      if (gld_dn == 0) begin gld_rsp_valid = 1'b1; gld_rsp_data = gld_pend; end
    end
    if (done) done_pulses = done_pulses + 1;
    if (acq_req_valid && acq_req_ready) begin
      acq_reqs = acq_reqs + 1;
      acq_pend = acq_mem[acq_req_addr[7:4]];
      acq_dn   = acq_lat;
    end
    if (gld_req_valid && gld_stall > 0) begin
      gld_req_ready = 1'b0;
      gld_stall     = gld_stall - 1;
    end else begin
      gld_req_ready = 1'b1;
    end
    if (gld_req_valid && gld_req_ready) begin
      gld_reqs = gld_reqs + 1;
      gld_pend = gld_mem[gld_req_addr[7:4]];
      gld_dn   = gld_lat;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 16; i++) begin
      gld_mem[i] = {4{32'hC3A5_0000 | 32'(i * 32'h0101)}};
      acq_mem[i] = gld_mem[i];
    end
  endtask

  // Issue one start pulse and wait (bounded) for the completion pulse.
  task automatic run(input logic [31:0] sa, input logic [31:0] ea, input logic md, input string tag);
    int d0;
    d0 = done_pulses;
    @(negedge clk);
    start_addr = sa; end_addr = ea; mode = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 500 && done_pulses == d0; k++) @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done_pulses - d0), 64'd1);
    @(negedge clk);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int a0, g0, d0;
    init_mem();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_cnt), 64'd0);
    chk("rst_chk", 64'(chk_cnt), 64'd0);
    chk("rst_fev", 64'(first_err_valid), 64'd0);
    chk("rst_valids", 64'({acq_req_valid, gld_req_valid}), 64'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Clean four-word range
    a0 = acq_reqs; g0 = gld_reqs;
    run(32'h000, 32'h03F, 1'b0, "clean");
    chk("clean_chk", 64'(chk_cnt), 64'd4);
    chk("clean_err", 64'(err_cnt), 64'd0);
    chk("clean_fev", 64'(first_err_valid), 64'd0);
    chk("clean_reqs", 64'({acq_reqs - a0, gld_reqs - g0}), {32'd4, 32'd4});

    // One flipped byte at 0x25 (word 0x20, byte 5)
    acq_mem[2][47:40] = ~acq_mem[2][47:40];
    run(32'h000, 32'h03F, 1'b0, "flip");
    chk("flip_chk", 64'(chk_cnt), 64'd4);
    chk("flip_err", 64'(err_cnt), 64'd1);
    chk("flip_fev", 64'(first_err_valid), 64'd1);
    chk("flip_fea", 64'(first_err_addr), 64'h20);
    init_mem();

    // Tolerance lanes: +8 ULP ok, +9 ULP fail, +0 vs -0 ok
    gld_mem[0] = {5{16'h1234}} ; acq_mem[0] = gld_mem[0];
    gld_mem[0][15:0]  = 16'h3C00; acq_mem[0][15:0]  = 16'h3C08;
    gld_mem[0][31:16] = 16'h3C00; acq_mem[0][31:16] = 16'h3C09;
    gld_mem[0][47:32] = 16'h0000; acq_mem[0][47:32] = 16'h8000;
    // Second word: +4 vs -4 (8 ULP) ok, +5 vs -5 (10) fail, 16 ULP fail
    gld_mem[1][15:0]  = 16'h0004; acq_mem[1][15:0]  = 16'h8004;
    gld_mem[1][31:16] = 16'h0005; acq_mem[1][31:16] = 16'h8005;
    gld_mem[1][47:32] = 16'h3C00; acq_mem[1][47:32] = 16'h3BF0;
    run(32'h000, 32'h00F, 1'b1, "tol1");
    chk("tol1_chk", 64'(chk_cnt), 64'd1);
    chk("tol1_err", 64'(err_cnt), 64'd1);
    chk("tol1_fea", 64'(first_err_addr), 64'h00);
    run(32'h010, 32'h01F, 1'b1, "tol2");
    chk("tol2_chk", 64'(chk_cnt), 64'd1);
`ifdef SAURIA_CHECKER_TOL_EN
    chk("tol2_err", 64'(err_cnt), 64'd2);
`else
    chk("tol2_err", 64'(err_cnt), 64'd1);
`endif
    chk("tol2_fea", 64'(first_err_addr), 64'h10);
    init_mem();

    // Golden stalled 5 cycles, golden responses trail acquired by 3 cycles
    acq_mem[3][0] = ~acq_mem[3][0];
    acq_lat = 1; gld_lat = 4; gld_stall = 5;
    a0 = acq_reqs; g0 = gld_reqs;
    run(32'h000, 32'h03F, 1'b0, "stall");
    chk("stall_chk", 64'(chk_cnt), 64'd4);
    chk("stall_err", 64'(err_cnt), 64'd1);
    chk("stall_fea", 64'(first_err_addr), 64'h30);
    chk("stall_reqs", 64'({acq_reqs - a0, gld_reqs - g0}), {32'd4, 32'd4});
    init_mem();

    // Abort one cycle after request acceptance, golden response still due
    acq_lat = 1; gld_lat = 6;
    a0 = acq_reqs; g0 = gld_reqs; d0 = done_pulses;
    @(negedge clk);
    start_addr = 32'h000; end_addr = 32'h03F; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_draining", 64'(busy), 64'd1);
    chk("abort_valids", 64'({acq_req_valid, gld_req_valid}), 64'd0);
    for (int k = 0; k < 50 && busy; k++) @(negedge clk);
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_rsp_drained", 64'(gld_dn), 64'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 64'(done_pulses - d0), 64'd0);
    chk("abort_chk", 64'(chk_cnt), 64'd0);
    chk("abort_reqs", 64'({acq_reqs - a0, gld_reqs - g0}), {32'd1, 32'd1});

    // Empty range: end below start
    acq_lat = 1; gld_lat = 1;
    a0 = acq_reqs;
    run(32'h010, 32'h00F, 1'b0, "empty");
    chk("empty_chk", 64'(chk_cnt), 64'd0);
    chk("empty_err", 64'(err_cnt), 64'd0);
    chk("empty_reqs", 64'(acq_reqs - a0), 64'd0);

    // Reset mid-transfer, late response must be ignored
    gld_lat = 6;
    @(negedge clk);
    start_addr = 32'h000; end_addr = 32'h03F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_valids", 64'({acq_req_valid, gld_req_valid}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    chk("mrst_idle", 64'(busy), 64'd0);
    chk("mrst_chk", 64'(chk_cnt), 64'd0);
    gld_lat = 1;
    run(32'h000, 32'h03F, 1'b0, "post_rst");
    chk("post_rst_chk", 64'(chk_cnt), 64'd4);
    chk("post_rst_err", 64'(err_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
